// File: rtl/cam_frame_writer.sv
// cam_frame_writer: drains the camera FIFO into fixed-length SDRAM write bursts,
// ping-ponging two frame buffers and publishing the last complete one to the VGA side.
module cam_frame_writer #(
  parameter int                BURST_LEN   = 256,
  parameter int                FRAME_WORDS = 76800,
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] BASE0       = 'h000000,
  parameter logic [ADDR_W-1:0] BASE1       = 'h020000
) (
  input  logic              S_CLK,
  input  logic              RST,
  input  logic              frame_start,
  input  logic [8:0]        r_usedw,
  output logic              r_req,
  input  logic [15:0]       r_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_len,
  input  logic              wr_ack,
  input  logic              wr_data_req,
  output logic [15:0]       wr_data,
  output logic              disp_bank,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] FW = CW'(FRAME_WORDS);
  localparam logic [31:0] BL32 = BURST_LEN;
  typedef enum logic [2:0] {IDLE, WAIT, REQ, BURST, DONE} state_t;
  state_t state, state_n;
  logic wr_bank, wr_bank_n, pend, pend_n, disp_bank_n, frame_err_n;
  logic [CW-1:0] count, count_n, rem;
  logic [8:0] bcnt, bcnt_n, len, wr_len_n;
  logic [ADDR_W-1:0] wr_addr_n, base;
  logic take, last, fin;
  assign rem = FW - count;
  assign len = 32'(rem) < BL32 ? 9'(rem) : 9'(BURST_LEN);
  assign base = wr_bank ? BASE1 : BASE0;
  assign take = state == BURST && wr_data_req;
  assign last = take && bcnt == wr_len - 9'd1;
  assign fin = last && count + CW'(wr_len) == FW;
  assign r_req = take;
  assign wr_data = r_data;
  assign wr_req = state == REQ;
  assign frame_done = state == DONE;
  always_comb begin
    state_n = state;
    wr_bank_n = wr_bank;
    pend_n = pend;
    disp_bank_n = disp_bank;
    count_n = count;
    bcnt_n = bcnt;
    wr_addr_n = wr_addr;
    wr_len_n = wr_len;
    // a start coinciding with the word that completes the frame is a normal start, not an error
    frame_err_n = frame_start && (state == WAIT || state == REQ || (state == BURST && !fin));
    case (state)
      IDLE: if (frame_start) begin
        count_n = '0;
        wr_addr_n = base;
        state_n = WAIT;
      end
      WAIT: if (frame_start) count_n = '0;
      else if (r_usedw >= len) begin
        wr_addr_n = base + ADDR_W'(count);
        wr_len_n = len;
        state_n = REQ;
      end
      REQ: begin
        pend_n = pend | frame_start;
        if (wr_ack) begin
          bcnt_n = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        pend_n = pend | frame_start;
        if (take) bcnt_n = bcnt + 9'd1;
        if (fin) begin
          count_n = FW;
          state_n = DONE;
        end else if (last && pend_n) begin
          count_n = '0;
          pend_n = 1'b0;
          state_n = WAIT;
        end else if (last) begin
          count_n = count + CW'(wr_len);
          state_n = WAIT;
        end
      end
      DONE: begin
        disp_bank_n = wr_bank;
        wr_bank_n = !wr_bank;
        if (frame_start || pend) begin
          count_n = '0;
          pend_n = 1'b0;
          wr_addr_n = wr_bank ? BASE0 : BASE1;
          state_n = WAIT;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state <= IDLE;
      wr_bank <= 1'b0;
      pend <= 1'b0;
      count <= '0;
      bcnt <= '0;
      wr_addr <= BASE0;
      wr_len <= '0;
      disp_bank <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      wr_bank <= wr_bank_n;
      pend <= pend_n;
      count <= count_n;
      bcnt <= bcnt_n;
      wr_addr <= wr_addr_n;
      wr_len <= wr_len_n;
      disp_bank <= disp_bank_n;
      frame_err <= frame_err_n;
    end
  end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: randomized-gap bench with FIFO/controller models and a frame/burst address model.
module tb_cam_frame_writer;
  localparam int FW = 1000;
  localparam int BL = 256;
  localparam int NB = (FW + BL - 1) / BL;
  localparam logic [21:0] B0 = 22'h000000;
  localparam logic [21:0] B1 = 22'h020000;
  logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, wr_ack = 1'b0, wr_data_req = 1'b0;
  logic r_req, wr_req, disp_bank, frame_done, frame_err;
  logic [8:0] r_usedw = '0, wr_len;
  logic [15:0] r_data = '0, wr_data;
  logic [21:0] wr_addr;
  logic [15:0] fifo[$];
  logic [15:0] push_val = '0, exp_word = '0;
  bit auto_fill = 1'b0;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;

  cam_frame_writer #(.FRAME_WORDS(FW), .BURST_LEN(BL)) dut (
    .S_CLK(clk), .RST(rst), .frame_start(frame_start), .r_usedw(r_usedw), .r_req(r_req),
    .r_data(r_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
    .wr_data_req(wr_data_req), .wr_data(wr_data), .disp_bank(disp_bank),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] b_addr(input bit bank, input int b);
    return (bank ? B1 : B0) + 22'(b * BL);
  endfunction

  function automatic int b_len(input int b);
    return (FW - b * BL) < BL ? FW - b * BL : BL;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back(push_val);
      push_val++;
    end
    r_usedw = fifo.size() > 511 ? 9'd511 : 9'(fifo.size());
  endtask

  task automatic cyc();
    logic pop;
    #1;
    pop = r_req;
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) r_data = fifo.pop_front();
    if (auto_fill && fifo.size() < 400) push(400 - fifo.size());
    r_usedw = fifo.size() > 511 ? 9'd511 : 9'(fifo.size());
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic do_burst(input logic [21:0] ea, input int el, input int inj, input int stop_at, input int extras);
    int n;
    n = 0;
    while (wr_req !== 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    chk("req_seen", 32'(n < 2000), 1);
    chk("wr_addr", 32'(wr_addr), 32'(ea));
    chk("wr_len", 32'(wr_len), 32'(el));
    cyc();
    chk("req_hold", {9'd0, wr_req, wr_addr}, {9'd0, 1'b1, ea});
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
    chk("req_drop", 32'(wr_req), 0);
    for (int i = 0; i < el + extras; i++) begin
      if (i == stop_at) return;
      repeat ($urandom_range(0, 2)) cyc();
      wr_data_req = 1'b1;
      frame_start = (i == inj);
      #1;
      chk("r_req", 32'(r_req), 32'(i < el));
      cyc();
      wr_data_req = 1'b0;
      frame_start = 1'b0;
      if (i < el) begin
        chk("wr_data", 32'(wr_data), 32'(exp_word));
        exp_word++;
      end
    end
  endtask

  task automatic run_frame(input bit bank, input int inj_b, input int inj_w);
    for (int b = 0; b < NB; b++)
      do_burst(b_addr(bank, b), b_len(b), b == inj_b ? inj_w : -1, -1,
               b == NB - 1 ? 0 : int'($urandom_range(0, 2)));
    chk("frame_done", 32'(frame_done), 1);
  endtask

  initial begin
    wr_data_req = 1'b1;
    repeat (3) cyc();
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_r_req", 32'(r_req), 0);
    chk("rst_wr_addr", 32'(wr_addr), 32'(B0));
    chk("rst_wr_len", 32'(wr_len), 0);
    chk("rst_disp", {29'd0, disp_bank, frame_done, frame_err}, 0);
    rst = 1'b0;
    wr_data_req = 1'b0;
    cyc();
    push(255);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("uflow_hold", 32'(wr_req), 0);
    end
    push(1);
    cyc();
    chk("uflow_go", 32'(wr_req), 1);
    auto_fill = 1'b1;
    run_frame(1'b0, -1, 0);
    cyc();
    chk("a_disp", 32'(disp_bank), 0);
    chk("a_done_cnt", 32'(done_cnt), 1);
    chk("a_err_cnt", 32'(err_cnt), 0);
    pulse_start();
    do_burst(b_addr(1'b1, 0), BL, -1, -1, int'($urandom_range(0, 2)));
    do_burst(b_addr(1'b1, 1), BL, -1, -1, int'($urandom_range(0, 2)));
    do_burst(b_addr(1'b1, 2), BL, 100, -1, int'($urandom_range(0, 2)));
    chk("mid_err_cnt", 32'(err_cnt), 1);
    chk("mid_disp", 32'(disp_bank), 0);
    run_frame(1'b1, -1, 0);
    cyc();
    chk("b_disp", 32'(disp_bank), 1);
    chk("b_done_cnt", 32'(done_cnt), 2);
    pulse_start();
    run_frame(1'b0, NB - 1, b_len(NB - 1) - 1);
    cyc();
    chk("c_disp", 32'(disp_bank), 0);
    chk("c_done_cnt", 32'(done_cnt), 3);
    chk("c_err_cnt", 32'(err_cnt), 1);
    do_burst(b_addr(1'b1, 0), BL, -1, -1, 0);
    pulse_start();
    chk("wait_err", 32'(frame_err), 1);
    do_burst(b_addr(1'b1, 0), BL, -1, 100, 0);
    rst = 1'b1;
    wr_data_req = 1'b1;
    cyc();
    chk("mrst_wr_req", 32'(wr_req), 0);
    chk("mrst_r_req", 32'(r_req), 0);
    chk("mrst_wr_addr", 32'(wr_addr), 32'(B0));
    chk("mrst_disp", 32'(disp_bank), 0);
    repeat (2) cyc();
    rst = 1'b0;
    wr_data_req = 1'b0;
    fifo.delete();
    exp_word = push_val;
    cyc();
    chk("post_rst_idle", 32'(wr_req), 0);
    pulse_start();
    do_burst(b_addr(1'b0, 0), BL, -1, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
